mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Arbitrates one single-ported 24-bit memory between three requesters: instruction fetch (port 0), processor data access (port 1), and the external program loader (port 2).
- Sits between the processor's fetch/data ports and the memory macro.
- Serialises accesses with a registered req/ack handshake and a fixed, parameterised memory read latency.

Parameters:
- AW, 24, address width.
- DW, 24, data width.
- MEM_LAT, 2, cycles from the mem_en cycle to valid mem_rdata. Legal range is 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  3  per-requester request; bit i belongs to port i.
- we  in  3  per-requester write enable.
- addr0, addr1, addr2  in  AW each  per-requester address.
- wdata0, wdata1, wdata2  in  DW each  per-requester write data.
- ack  out  3  one-cycle completion pulse per requester.
- rdata  out  DW  registered read data, valid while the ack bit is high.
- busy  out  1  high whenever the state is not IDLE.
- gnt_id  out  2  index of the granted port; 2'b11 when no grant.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.

Behaviour:
- Reset (rst=0, asynchronous): effective immediately, not at the next edge.
  - State goes to IDLE.
  - ack, rdata, mem_en, mem_we, mem_addr and mem_wdata go to 0. busy goes to 0. gnt_id goes to 2'b11.
  - The round-robin pointer (if compiled in) goes to 2.
  - A transaction in flight is abandoned and is never acked.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - At each edge, if req!=0: pick a winner, latch its we/addr/wdata into the mem_* registers, set gnt_id, and go to ISSUE.
  - Default priority is fixed: port 1 > port 0 > port 2.
- ISSUE: exactly one cycle with mem_en=1. mem_we, mem_addr and mem_wdata are stable. Next state is WAIT.
- WAIT:
  - mem_en=0. A counter counts MEM_LAT-1 further cycles.
  - At the edge where mem_rdata is valid (MEM_LAT cycles after the ISSUE cycle), capture mem_rdata into rdata (reads only) and go to DONE.
  - With MEM_LAT=1, WAIT lasts 0 cycles: the capture happens at the end of ISSUE and the next state is DONE.
- DONE:
  - ack[gnt_id]=1 for exactly one cycle, then go to IDLE.
  - gnt_id returns to 2'b11 on entry to IDLE.
- Latency: req sampled at edge t gives ISSUE in cycle t+1 and ack in cycle t+MEM_LAT+1. Occupancy is MEM_LAT+2 cycles per access, including the IDLE arbitration cycle.
- Requester rules: hold req, we, addr and wdata until ack, then drop req on the edge ending the ack cycle. DONE always returns to IDLE, so a properly dropped req is never served twice.
- req dropped mid-transaction: ignored. The access completes and ack still pulses.
- Writes: ack pulses and rdata keeps its previous value.
- Only one ack bit is ever high. ack and busy are never both low while a transaction is pending.
- Requests arriving while busy are held off. No queueing; the requester keeps req high.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - IDLE picks the first requesting port searching upward (mod 3) from ptr+1, where ptr is the last served port.
  - ptr updates on entering ISSUE. Reset value of ptr is 2, so port 0 is searched first.
  - A continuously requesting port waits at most 2 other grants.
- Undefined: fixed priority 1 > 0 > 2 applies and no pointer register exists.

Test Plan:
- Reset/idle: rst=0 then 1 with req=0 -> ack=0, busy=0, gnt_id=2'b11, mem_en never asserted over 20 cycles.
- Single read: MEM_LAT=2, req=3'b001, addr0=24'h000010, mem_rdata model returns 24'hABCDEF -> mem_en high exactly 1 cycle with mem_addr=24'h000010, mem_we=0; ack=3'b001 in cycle t+3 with rdata=24'hABCDEF.
- Write: req=3'b010, we=3'b010, addr1=24'h0000FF, wdata1=24'h123456 -> mem_we=1, mem_wdata=24'h123456 in the ISSUE cycle; ack=3'b010 after MEM_LAT+1 cycles; rdata unchanged.
- Contention, default build: req=3'b111 held, each port dropping req after its ack -> grant order 1, 0, 2. With ARB_ROUND_ROBIN_EN and all three held continuously -> order 0, 1, 2, 0, 1, 2.
- Reset mid-operation: rst=0 during WAIT -> mem_en=0, busy=0 and gnt_id=2'b11 before the next clk edge; no ack ever issued for that access.
- MEM_LAT=1 sweep: back-to-back reads from port 0 -> ack every 3 cycles, rdata matches the model each time.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundles the requester and memory-macro signals of mem_port_arbiter.
// The arbiter takes the slave view. The requesters and memory model take the master view.
interface mem_port_arbiter_if #(
    parameter int AW = 24,
    parameter int DW = 24
);
    logic [2:0]    req;
    logic [2:0]    we;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [AW-1:0] addr2;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic [DW-1:0] wdata2;
    logic [2:0]    ack;
    logic [DW-1:0] rdata;
    logic          busy;
    logic [1:0]    gnt_id;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2, mem_rdata,
        output ack, rdata, busy, gnt_id, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2, mem_rdata,
        input  ack, rdata, busy, gnt_id, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Three-port arbiter for a single-ported memory with fixed read latency MEM_LAT.
// Define ARB_ROUND_ROBIN_EN to replace fixed priority (1 > 0 > 2) with round-robin.
module mem_port_arbiter #(
    parameter int AW      = 24,
    parameter int DW      = 24,
    parameter int MEM_LAT = 2
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(MEM_LAT - 2);

    state_t        state_q, state_d;
    logic [2:0]    ack_q, ack_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          busy_q, busy_d;
    logic [1:0]    gnt_q, gnt_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [1:0]    winner;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] ptr_q, ptr_d;

    // Search upward from the port after the last one served.
    always_comb begin
        winner = 2'd0;
        case (ptr_q)
            2'd0:    winner = bus.req[1] ? 2'd1 : (bus.req[2] ? 2'd2 : 2'd0);
            2'd1:    winner = bus.req[2] ? 2'd2 : (bus.req[0] ? 2'd0 : 2'd1);
            default: winner = bus.req[0] ? 2'd0 : (bus.req[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == S_IDLE && |bus.req) ptr_d = winner;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= 2'd2;
        else      ptr_q <= ptr_d;
    end
`else
    always_comb begin
        winner = bus.req[1] ? 2'd1 : (bus.req[0] ? 2'd0 : 2'd2);
    end
`endif

    always_comb begin
        sel_addr  = bus.addr2;
        sel_wdata = bus.wdata2;
        case (winner)
            2'd0:    begin sel_addr = bus.addr0; sel_wdata = bus.wdata0; end
            2'd1:    begin sel_addr = bus.addr1; sel_wdata = bus.wdata1; end
            default: begin sel_addr = bus.addr2; sel_wdata = bus.wdata2; end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ack_d       = ack_q;
        rdata_d     = rdata_q;
        gnt_d       = gnt_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    state_d     = S_ISSUE;
                    mem_en_d    = 1'b1;
                    mem_we_d    = bus.we[winner];
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    gnt_d       = winner;
                end
            end
            S_ISSUE: begin
                mem_en_d = 1'b0;
                // With a one-cycle memory the read data is already valid here.
                if (MEM_LAT == 1) begin
                    state_d = S_DONE;
                    ack_d   = 3'b001 << gnt_q;
                    if (!mem_we_q) rdata_d = bus.mem_rdata;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = WAIT_INIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                    ack_d   = 3'b001 << gnt_q;
                    if (!mem_we_q) rdata_d = bus.mem_rdata;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                ack_d   = 3'b000;
                gnt_d   = 2'b11;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ack_q       <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            gnt_q       <= 2'b11;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            gnt_q       <= gnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = busy_q;
    assign bus.gnt_id    = gnt_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LAT=2 and one with MEM_LAT=1.
// The memory models return a fixed address pattern, or a marker word when no read is due.
module tb_mem_port_arbiter;
    localparam logic [23:0] GARBAGE = 24'hDEAD00;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    mem_port_arbiter_if #(.AW(24), .DW(24)) bus2 ();
    mem_port_arbiter_if #(.AW(24), .DW(24)) bus1 ();

    mem_port_arbiter #(.AW(24), .DW(24), .MEM_LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    mem_port_arbiter #(.AW(24), .DW(24), .MEM_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] model(input logic [23:0] a);
        return (a == 24'h000010) ? 24'hABCDEF : (a ^ 24'h5A5A5A);
    endfunction

    // Two-cycle memory: data is valid in the cycle after the strobe.
    logic        rv2;
    logic [23:0] rd2;
    always @(posedge clk) begin
        rv2 <= bus2.mem_en && !bus2.mem_we;
        rd2 <= model(bus2.mem_addr);
    end
    assign bus2.mem_rdata = rv2 ? rd2 : GARBAGE;

    // One-cycle memory: data is valid during the strobe cycle itself.
    assign bus1.mem_rdata = (bus1.mem_en && !bus1.mem_we) ? model(bus1.mem_addr) : GARBAGE;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int en_seen;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if (bus2.ack !== 3'b000 || bus2.busy !== 1'b0 || bus2.gnt_id !== 2'b11) begin
            tests_failed++;
            $display("FAIL reset_outputs: ack=%b busy=%b gnt=%b required ack=000 busy=0 gnt=11",
                     bus2.ack, bus2.busy, bus2.gnt_id);
        end
        tests_run++;
        if (bus2.mem_en !== 1'b0 || bus2.mem_addr !== 24'h0 || bus2.rdata !== 24'h0 || bus1.gnt_id !== 2'b11) begin
            tests_failed++;
            $display("FAIL reset_mem: mem_en=%b mem_addr=%h rdata=%h gnt1=%b required 0/000000/000000/11",
                     bus2.mem_en, bus2.mem_addr, bus2.rdata, bus1.gnt_id);
        end
        tick();
        rst = 1'b1;
        en_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus2.mem_en !== 1'b0 || bus2.busy !== 1'b0 || bus2.gnt_id !== 2'b11 || bus1.mem_en !== 1'b0)
                en_seen++;
        end
        tests_run++;
        if (en_seen != 0) begin
            tests_failed++;
            $display("FAIL idle_quiet: %0d active cycles required 0", en_seen);
        end
        $display("[TB] reset/idle done");
    endtask

    task automatic test_single_read();
        bus2.addr0 = 24'h000010;
        bus2.we    = 3'b000;
        bus2.req   = 3'b001;
        tick();
        tests_run++;
        if (bus2.mem_en !== 1'b1 || bus2.mem_addr !== 24'h000010 || bus2.mem_we !== 1'b0 || bus2.gnt_id !== 2'd0 || bus2.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL read_issue: en=%b addr=%h we=%b gnt=%0d busy=%b required 1/000010/0/0/1",
                     bus2.mem_en, bus2.mem_addr, bus2.mem_we, bus2.gnt_id, bus2.busy);
        end
        tick();
        tests_run++;
        if (bus2.mem_en !== 1'b0 || bus2.ack !== 3'b000) begin
            tests_failed++;
            $display("FAIL read_wait: en=%b ack=%b required 0/000", bus2.mem_en, bus2.ack);
        end
        tick();
        tests_run++;
        if (bus2.ack !== 3'b001 || bus2.rdata !== 24'hABCDEF) begin
            tests_failed++;
            $display("FAIL read_ack: ack=%b rdata=%h required 001/abcdef", bus2.ack, bus2.rdata);
        end
        tick();
        bus2.req = 3'b000;
        tests_run++;
        if (bus2.ack !== 3'b000 || bus2.gnt_id !== 2'b11 || bus2.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_end: ack=%b gnt=%b busy=%b required 000/11/0", bus2.ack, bus2.gnt_id, bus2.busy);
        end
        tick();
        tick();
        tests_run++;
        if (bus2.mem_en !== 1'b0 || bus2.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_no_repeat: en=%b busy=%b required 0/0", bus2.mem_en, bus2.busy);
        end
        $display("[TB] read port0 addr=000010 rdata=%h", bus2.rdata);
    endtask

    task automatic test_write();
        bus2.addr1  = 24'h0000FF;
        bus2.wdata1 = 24'h123456;
        bus2.we     = 3'b010;
        bus2.req    = 3'b010;
        tick();
        tests_run++;
        if (bus2.mem_en !== 1'b1 || bus2.mem_we !== 1'b1 || bus2.mem_addr !== 24'h0000FF || bus2.mem_wdata !== 24'h123456 || bus2.gnt_id !== 2'd1) begin
            tests_failed++;
            $display("FAIL write_issue: en=%b we=%b addr=%h wdata=%h gnt=%0d required 1/1/0000ff/123456/1",
                     bus2.mem_en, bus2.mem_we, bus2.mem_addr, bus2.mem_wdata, bus2.gnt_id);
        end
        tick();
        tests_run++;
        if (bus2.ack !== 3'b000) begin
            tests_failed++;
            $display("FAIL write_early_ack: ack=%b required 000", bus2.ack);
        end
        tick();
        tests_run++;
        if (bus2.ack !== 3'b010 || bus2.rdata !== 24'hABCDEF) begin
            tests_failed++;
            $display("FAIL write_ack: ack=%b rdata=%h required 010/abcdef", bus2.ack, bus2.rdata);
        end
        tick();
        bus2.req = 3'b000;
        bus2.we  = 3'b000;
        tick();
        $display("[TB] write port1 addr=0000ff wdata=123456");
    endtask

    task automatic test_contention();
        int          n;
        int          e;
        logic [2:0]  exp_ack;
        logic [23:0] exp_addr;
`ifdef ARB_ROUND_ROBIN_EN
        int          order[6] = '{0, 1, 2, 0, 1, 2};
        int          grants = 6;
`else
        int          order[6] = '{1, 0, 2, 0, 0, 0};
        int          grants = 3;
`endif
        bus2.addr0 = 24'h000020;
        bus2.addr1 = 24'h000021;
        bus2.addr2 = 24'h000022;
        bus2.we    = 3'b000;
        bus2.req   = 3'b111;
        for (int g = 0; g < grants; g++) begin
            e        = order[g];
            exp_ack  = 3'b001 << e;
            exp_addr = 24'h000020 + 24'(e);
            n = 0;
            do begin
                tick();
                n++;
            end while (bus2.ack === 3'b000 && n < 12);
            tests_run++;
            if (bus2.ack !== exp_ack || bus2.gnt_id !== 2'(e) || bus2.rdata !== model(exp_addr)) begin
                tests_failed++;
                $display("FAIL grant_%0d: ack=%b gnt=%b rdata=%h required %b/%0d/%h",
                         g, bus2.ack, bus2.gnt_id, bus2.rdata, exp_ack, e, model(exp_addr));
            end
            $display("[TB] grant %0d -> port %0d rdata=%h", g, bus2.gnt_id, bus2.rdata);
`ifdef ARB_ROUND_ROBIN_EN
            if (g == grants - 1) bus2.req = 3'b000;
`else
            tick();
            bus2.req[e] = 1'b0;
`endif
        end
        bus2.req = 3'b000;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        int late;
        bus2.addr2 = 24'h000040;
        bus2.we    = 3'b000;
        bus2.req   = 3'b100;
        tick();
        tick();
        tests_run++;
        if (bus2.busy !== 1'b1 || bus2.mem_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_in_wait: busy=%b en=%b required 1/0", bus2.busy, bus2.mem_en);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus2.busy !== 1'b0 || bus2.mem_en !== 1'b0 || bus2.gnt_id !== 2'b11 || bus2.rdata !== 24'h0) begin
            tests_failed++;
            $display("FAIL abort_async: busy=%b en=%b gnt=%b rdata=%h required 0/0/11/000000",
                     bus2.busy, bus2.mem_en, bus2.gnt_id, bus2.rdata);
        end
        bus2.req = 3'b000;
        tick();
        rst  = 1'b1;
        late = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus2.ack !== 3'b000 || bus2.busy !== 1'b0) late++;
        end
        tests_run++;
        if (late != 0) begin
            tests_failed++;
            $display("FAIL abort_no_ack: %0d cycles with ack/busy required 0", late);
        end
        $display("[TB] aborted port2 access");
    endtask

    task automatic test_back_to_back();
        logic [23:0] addrs[4] = '{24'h000010, 24'h000031, 24'h000032, 24'h000033};
        int n;
        bus1.we    = 3'b000;
        bus1.addr0 = addrs[0];
        bus1.req   = 3'b001;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (bus1.ack === 3'b000 && n < 10);
            tests_run++;
            if (n != ((k == 0) ? 2 : 3) || bus1.ack !== 3'b001 || bus1.rdata !== model(addrs[k])) begin
                tests_failed++;
                $display("FAIL b2b_%0d: cycles=%0d ack=%b rdata=%h required %0d/001/%h",
                         k, n, bus1.ack, bus1.rdata, (k == 0) ? 2 : 3, model(addrs[k]));
            end
            $display("[TB] lat1 read %0d addr=%h rdata=%h after %0d cycles", k, addrs[k], bus1.rdata, n);
            if (k < 3) bus1.addr0 = addrs[k + 1];
            else       bus1.req   = 3'b000;
        end
        tick();
        tick();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        bus2.req = 3'b000; bus2.we = 3'b000;
        bus2.addr0 = '0; bus2.addr1 = '0; bus2.addr2 = '0;
        bus2.wdata0 = '0; bus2.wdata1 = '0; bus2.wdata2 = '0;
        bus1.req = 3'b000; bus1.we = 3'b000;
        bus1.addr0 = '0; bus1.addr1 = '0; bus1.addr2 = '0;
        bus1.wdata0 = '0; bus1.wdata1 = '0; bus1.wdata2 = '0;

        test_reset();
        test_single_read();
        test_write();
        test_contention();
        test_reset_mid();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
